// File: rtl/tt_pi_ctrl_if.sv
// Error-sample / control-word bundle between the phase detector, the PI loop filter and the DCO.
// The master modport is the detector/testbench side; the slave modport is the loop filter.
interface tt_pi_ctrl_if #(
    parameter int ERR_W  = 16,
    parameter int CTRL_W = 16
);
    logic                     i_enable;
    logic                     i_err_valid;
    logic signed [ERR_W-1:0]  i_err;
    logic                     o_err_ready;
    logic signed [CTRL_W-1:0] o_control;
    logic                     o_control_valid;
    logic                     o_sat;
    logic                     o_locked;

    modport master (
        output i_enable, i_err_valid, i_err,
        input  o_err_ready, o_control, o_control_valid, o_sat, o_locked
    );

    modport slave (
        input  i_enable, i_err_valid, i_err,
        output o_err_ready, o_control, o_control_valid, o_sat, o_locked
    );
endinterface

// File: rtl/tt_pi_ctrl.sv
// PI loop filter driving the DCO control word: 2-stage pipeline, saturating output, anti-windup integrator.
// Optional lock detector enabled by defining TT_PI_CTRL_LOCK_DET_EN.
module tt_pi_ctrl #(
    parameter int ERR_W       = 16,
    parameter int CTRL_W      = 16,
    parameter int INT_W       = 24,
    parameter int KP_SHIFT    = 2,
    parameter int KI_SHIFT    = 6,
    parameter int LOCK_THRESH = 64,
    parameter int LOCK_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    tt_pi_ctrl_if.slave bus
);

`ifdef TT_PI_CTRL_LOCK_DET_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} state_t;
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic signed [ERR_W:0]   THR1     = (ERR_W+1)'(LOCK_THRESH);
    localparam logic signed [ERR_W:0]   THR2     = (ERR_W+1)'(2 * LOCK_THRESH);
`else
    typedef enum logic {ST_IDLE, ST_ACQUIRE} state_t;
`endif

    // Saturation bounds expressed at the INT_W+1 working width.
    localparam logic signed [INT_W:0] INT_MAX  = {2'b00, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W:0] INT_MIN  = {2'b11, {(INT_W-1){1'b0}}};
    localparam logic signed [INT_W:0] CTRL_MAX = {{(INT_W-CTRL_W+2){1'b0}}, {(CTRL_W-1){1'b1}}};
    localparam logic signed [INT_W:0] CTRL_MIN = {{(INT_W-CTRL_W+2){1'b1}}, {(CTRL_W-1){1'b0}}};

    state_t                   state_reg;
    logic signed [INT_W-1:0]  integ_reg;
    logic signed [ERR_W-1:0]  p_reg;
    logic                     s1_valid_reg;
    logic                     clamp_hi_reg;
    logic                     clamp_lo_reg;
    logic signed [CTRL_W-1:0] control_reg;
    logic                     control_valid_reg;
    logic                     sat_reg;

    logic signed [ERR_W-1:0]  err_in;
    logic signed [ERR_W-1:0]  p_next;
    logic signed [INT_W:0]    integ_sum;
    logic signed [INT_W-1:0]  integ_next;
    logic                     skip_integ;
    logic signed [INT_W-1:0]  integ_shift;
    logic signed [INT_W:0]    ctrl_sum;
    logic                     clamp_hi;
    logic                     clamp_lo;
    logic signed [CTRL_W-1:0] ctrl_next;

    assign err_in      = bus.i_err;
    assign p_next      = err_in >>> KP_SHIFT;
    assign integ_shift = integ_reg >>> KI_SHIFT;
    assign integ_sum   = {integ_reg[INT_W-1], integ_reg}
                       + {{(INT_W+1-ERR_W){err_in[ERR_W-1]}}, err_in};
    assign ctrl_sum    = {{(INT_W+1-ERR_W){p_reg[ERR_W-1]}}, p_reg}
                       + {integ_shift[INT_W-1], integ_shift};

    // Freeze the integrator while the output is pinned and the error pushes further into the rail.
    assign skip_integ = (clamp_hi_reg && !err_in[ERR_W-1] && (err_in != '0))
                     || (clamp_lo_reg && err_in[ERR_W-1]);

    assign clamp_hi = ctrl_sum > CTRL_MAX;
    assign clamp_lo = ctrl_sum < CTRL_MIN;

    always_comb begin
        integ_next = integ_sum[INT_W-1:0];
        if (integ_sum > INT_MAX)
            integ_next = INT_MAX[INT_W-1:0];
        else if (integ_sum < INT_MIN)
            integ_next = INT_MIN[INT_W-1:0];
    end

    always_comb begin
        ctrl_next = ctrl_sum[CTRL_W-1:0];
        if (clamp_hi)
            ctrl_next = CTRL_MAX[CTRL_W-1:0];
        else if (clamp_lo)
            ctrl_next = CTRL_MIN[CTRL_W-1:0];
    end

`ifdef TT_PI_CTRL_LOCK_DET_EN
    logic signed [ERR_W:0] err_ext;
    logic                  in_lock;
    logic                  out_lock;
    logic                  in_lock_reg;
    logic                  out_lock_reg;
    logic [CNT_W-1:0]      lock_cnt_reg;
    logic                  locked_reg;

    assign err_ext  = {err_in[ERR_W-1], err_in};
    assign in_lock  = (err_ext <= THR1) && (err_ext >= -THR1);
    assign out_lock = (err_ext > THR2) || (err_ext < -THR2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            in_lock_reg  <= 1'b0;
            out_lock_reg <= 1'b0;
            lock_cnt_reg <= '0;
            locked_reg   <= 1'b0;
        end else if (!bus.i_enable) begin
            in_lock_reg  <= 1'b0;
            out_lock_reg <= 1'b0;
            lock_cnt_reg <= '0;
            locked_reg   <= 1'b0;
        end else begin
            if (bus.i_err_valid) begin
                in_lock_reg  <= in_lock;
                out_lock_reg <= out_lock;
            end
            // Lock status advances with the result of the sample, one edge after acceptance.
            if (s1_valid_reg) begin
                if (state_reg == ST_LOCKED) begin
                    if (out_lock_reg) begin
                        locked_reg   <= 1'b0;
                        lock_cnt_reg <= '0;
                    end
                end else if (in_lock_reg) begin
                    if (lock_cnt_reg == CNT_LAST) begin
                        locked_reg   <= 1'b1;
                        lock_cnt_reg <= '0;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 1'b1;
                    end
                end else begin
                    lock_cnt_reg <= '0;
                end
            end
        end
    end

    assign bus.o_locked = locked_reg;
`else
    assign bus.o_locked = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg         <= ST_IDLE;
            integ_reg         <= '0;
            p_reg             <= '0;
            s1_valid_reg      <= 1'b0;
            clamp_hi_reg      <= 1'b0;
            clamp_lo_reg      <= 1'b0;
            control_reg       <= '0;
            control_valid_reg <= 1'b0;
            sat_reg           <= 1'b0;
        end else if (!bus.i_enable) begin
            // Dropping enable discards any in-flight sample and parks the DCO at mid-range.
            state_reg         <= ST_IDLE;
            integ_reg         <= '0;
            p_reg             <= '0;
            s1_valid_reg      <= 1'b0;
            clamp_hi_reg      <= 1'b0;
            clamp_lo_reg      <= 1'b0;
            control_reg       <= '0;
            control_valid_reg <= 1'b0;
            sat_reg           <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE)
                state_reg <= ST_ACQUIRE;
            control_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                control_reg  <= ctrl_next;
                sat_reg      <= clamp_hi || clamp_lo;
                clamp_hi_reg <= clamp_hi;
                clamp_lo_reg <= clamp_lo;
`ifdef TT_PI_CTRL_LOCK_DET_EN
                if (state_reg == ST_LOCKED && out_lock_reg)
                    state_reg <= ST_ACQUIRE;
                else if (state_reg == ST_ACQUIRE && in_lock_reg && lock_cnt_reg == CNT_LAST)
                    state_reg <= ST_LOCKED;
`endif
            end
            s1_valid_reg <= bus.i_err_valid;
            if (bus.i_err_valid) begin
                p_reg <= p_next;
                if (!skip_integ)
                    integ_reg <= integ_next;
            end
        end
    end

    assign bus.o_err_ready     = bus.i_enable;
    assign bus.o_control       = control_reg;
    assign bus.o_control_valid = control_valid_reg;
    assign bus.o_sat           = sat_reg;

endmodule
